// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states (RUN / HALT / FAULT)
//   INSTR_BYTES   : bytes per instruction word (defines PC alignment)
//   PC_INC        : sequential PC step
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_HALT  = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES = 4;
    localparam int PC_INC      = 4;

endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: valid/ready output register between fetch and decode.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_load           : capture i_instr/i_pc and mark valid
//   i_flush          : drop the held entry (wins over i_load)
//   i_ready          : downstream accepts the held entry this cycle
//   i_instr, i_pc    : instruction and its address to capture
//   o_valid, o_instr, o_pc : registered output toward decode
module fetch_out_reg
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic                     i_flush,
    input  logic                     i_ready,
    input  logic [DATA_WIDTH-1:0]    i_instr,
    input  logic [ADDRESS_WIDTH-1:0] i_pc,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_instr,
    output logic [ADDRESS_WIDTH-1:0] o_pc
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDRESS_WIDTH-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            // Accepted with nothing new behind it (halt drain): go empty.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, addresses a combinational
// instruction memory and registers the fetched word toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> FAULT).
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   imem_addr / imem_data           : instruction memory address (= PC) / data
//   redirect_valid, redirect_target : branch/jump redirect
//   halt_req                        : stop fetching
//   out_valid/out_ready/out_instr/out_pc : output handshake to decode
//   halted, misalign                : status (misalign sticky, macro only)
//   fetch_count                     : instructions accepted by decode
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     halt_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     halted,
    output logic                     misalign,
    output logic [31:0]              fetch_count
);

    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(INSTR_BYTES - 1);

    fetch_state_e             r_state;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [31:0]              r_fetch_count;

    logic                     w_redirect;
    logic                     w_fault_now;
    logic                     w_load;
    logic                     w_accept;
    logic [ADDRESS_WIDTH-1:0] w_target;

    assign w_accept   = out_valid && out_ready;
    // FAULT ignores redirects; only reset leaves it.
    assign w_redirect = redirect_valid && (r_state != FS_FAULT);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Keep the raw target so the offending address is visible in the PC.
    assign w_target    = redirect_target;
    assign w_fault_now = w_redirect && ((redirect_target & ALIGN_MASK) != '0);
`else
    assign w_target    = redirect_target & ~ALIGN_MASK;
    assign w_fault_now = 1'b0;
`endif

    // Capture only in RUN with no redirect/halt and the output slot free.
    assign w_load = (r_state == FS_RUN) && !redirect_valid && !halt_req &&
                    (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FS_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            // Counted even on a redirect cycle: the entry was taken before the flush.
            if (w_accept)
                r_fetch_count <= r_fetch_count + 32'd1;

            if (w_redirect) begin
                r_pc    <= w_target;
                r_state <= w_fault_now ? FS_FAULT : FS_RUN;
            end else if (r_state == FS_RUN && halt_req) begin
                r_state <= FS_HALT;
            end else if (w_load) begin
                r_pc <= r_pc + ADDRESS_WIDTH'(PC_INC);  // wraps silently
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (w_fault_now)
            r_misalign <= 1'b1;
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    fetch_out_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_redirect),
        .i_ready (out_ready),
        .i_instr (imem_data),
        .i_pc    (r_pc),
        .o_valid (out_valid),
        .o_instr (out_instr),
        .o_pc    (out_pc)
    );

    assign imem_addr   = r_pc;
    assign halted      = (r_state != FS_RUN);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit with a
// cycle-level behavioural model. Memory word k holds value k.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misalign;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr >> 2;

    fetch_unit #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .halted          (halted),
        .misalign        (misalign),
        .fetch_count     (fetch_count)
    );

    // Reference model: mode 0 = fetching, 1 = halted, 2 = faulted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_opc, m_cnt;
    logic        m_valid, m_mis;

    task automatic model_edge(input logic r, input logic rv, input logic [31:0] rt,
                              input logic hr, input logic rdy);
        logic taken;
        if (r) begin
            m_mode = 0; m_pc = 0; m_instr = 0; m_opc = 0; m_cnt = 0;
            m_valid = 0; m_mis = 0;
            return;
        end
        taken = m_valid && rdy;
        if (taken) m_cnt = m_cnt + 1;
        if (rv && m_mode != 2) begin
            m_valid = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc = rt;
            if (rt % 4 != 0) begin m_mode = 2; m_mis = 1; end
            else m_mode = 0;
`else
            m_pc = rt - (rt % 4);
            m_mode = 0;
`endif
        end else if (m_mode == 0 && hr) begin
            m_mode = 1;
            if (taken) m_valid = 0;
        end else if (m_mode == 0) begin
            if (!m_valid || rdy) begin
                m_instr = m_pc / 4;
                m_opc   = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end else if (taken) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr",   imem_addr,          m_pc);
        chk("out_valid",   {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_instr",   out_instr,          m_instr);
        chk("out_pc",      out_pc,             m_opc);
        chk("halted",      {31'd0, halted},    {31'd0, m_mode != 0});
        chk("misalign",    {31'd0, misalign},  {31'd0, m_mis});
        chk("fetch_count", fetch_count,        m_cnt);
    endtask

    task automatic step(input logic rv, input logic [31:0] rt, input logic hr,
                        input logic rdy, input logic r = 1'b0);
        rst = r; redirect_valid = rv; redirect_target = rt;
        halt_req = hr; out_ready = rdy;
        @(posedge clk);
        model_edge(r, rv, rt, hr, rdy);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        halt_req = 1'b0; out_ready = 1'b1;
        m_mode = 0; m_pc = 0; m_instr = 0; m_opc = 0; m_cnt = 0; m_valid = 0; m_mis = 0;

        // Reset state
        step(0, 0, 0, 1, 1);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);

        // Sequential fetch: out_pc 0,4,8
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("seq_pc8", out_pc, 32'h8);
        chk("seq_cnt", fetch_count, 32'd2);

        // Stall three cycles at out_pc=8
        repeat (3) step(0, 0, 0, 0);
        chk("stall_pc", out_pc, 32'h8);
        chk("stall_addr", imem_addr, 32'hC);
        step(0, 0, 0, 1);
        chk("release_pc", out_pc, 32'hC);

        // Advance to out_pc=0x10, stall, redirect to 0x40
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 32'h40, 0, 0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(0, 0, 0, 1);
        chk("redir_pc", out_pc, 32'h40);
        chk("redir_instr", out_instr, 32'd16);

        // Halt at PC=0x20 with a pending stalled output, drain, resume
        step(1, 32'h20, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("halt_addr", imem_addr, 32'h24);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("halt_drained", {31'd0, out_valid}, 32'd0);
        step(1, 32'h0, 0, 1);
        step(0, 0, 0, 1);
        chk("resume_halted", {31'd0, halted}, 32'd0);

        // Redirect + accept in the same cycle still counts
        step(1, 32'h100, 0, 1);

        // PC wrap
        step(1, 32'hFFFF_FFFC, 0, 1);
        step(0, 0, 0, 1);
        chk("wrap_top", out_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_zero", out_pc, 32'h0);

        // Misaligned redirect
        step(1, 32'h42, 0, 1);
        step(0, 0, 0, 1);
        step(1, 32'h80, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1, 1);

        // Reset mid-operation
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | t[3:0];
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            step($urandom_range(0, 9) == 0, t, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
